ex_mem_pipe: RTL and testbench
==============================

Name: ex_mem_pipe

Overview:
- Parametrised EX->MEM pipeline register for the five-stage MIPS core.
- Adds four things over a plain stage latch: stall hold, bubble insertion, flush, and a valid bit.
- Stores partial-result state (hilo_temp, cnt) for multi-cycle EX ops such as madd/msub, so EX can resume after a stall.
- Sits between ex and mem; its stall slice is driven by ctrl.

Parameters:
- DATA_W, 32, GPR/HI/LO/address width
- REG_ADDR_W, 5, destination register index width
- ALUOP_W, 8, aluop code width
- CNT_W, 2, multi-cycle step counter width
- STALL_W, 6, width of the ctrl stall vector
- STAGE_IDX, 3, bit of stall belonging to EX; bit STAGE_IDX+1 belongs to MEM (STAGE_IDX+1 < STALL_W)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active-high
- stall  in  STALL_W  per-stage stall vector from ctrl
- flush  in  1  kill the EX-stage entry (exception/redirect)
- ex_valid  in  1  EX holds a real instruction
- ex_wd  in  REG_ADDR_W  destination register
- ex_wreg  in  1  GPR write enable
- ex_wdata  in  DATA_W  GPR write data
- ex_hi  in  DATA_W  HI write data
- ex_lo  in  DATA_W  LO write data
- ex_whilo  in  1  HI/LO write enable
- ex_aluop  in  ALUOP_W  op code forwarded to MEM
- ex_mem_addr  in  DATA_W  load/store effective address
- ex_reg2  in  DATA_W  store data
- ex_hilo_temp  in  2*DATA_W  partial product from EX
- ex_cnt  in  CNT_W  EX multi-cycle step
- mem_valid  out  1  MEM entry is real
- mem_wd, mem_wreg, mem_wdata, mem_hi, mem_lo, mem_whilo, mem_aluop, mem_mem_addr, mem_reg2  out  same widths as the ex_ inputs  registered copies
- hilo_temp_o  out  2*DATA_W  saved partial product, fed back to EX
- cnt_o  out  CNT_W  saved step, fed back to EX

Behaviour:
- Interface: reset rst, synchronous, active-high; clock clk. All outputs are registers updated on the rising edge of clk.
- Let sE = stall[STAGE_IDX] and sM = stall[STAGE_IDX+1]. Each cycle exactly one action applies, in this priority order:
  1. rst: every output = 0. mem_aluop = NOP_OP (0).
  2. flush: bubble. hilo_temp_o = 0, cnt_o = 0.
  3. sE && !sM: bubble. hilo_temp_o <= ex_hilo_temp, cnt_o <= ex_cnt. This saves multi-cycle progress.
  4. sE && sM: hold. Every output keeps its value, including hilo_temp_o and cnt_o.
  5. otherwise: advance. All mem_* outputs <= ex_* inputs, mem_valid <= ex_valid. hilo_temp_o = 0, cnt_o = 0.
- Bubble means:
  - mem_valid = 0, mem_wreg = 0, mem_whilo = 0, mem_aluop = NOP_OP.
  - mem_wd = 0, mem_wdata = 0, mem_hi = 0, mem_lo = 0, mem_mem_addr = 0, mem_reg2 = 0.
- Latency: 1 cycle from EX to MEM.
- !sE && sM is an illegal ctrl encoding. It is treated as hold and flagged by a simulation-only assertion.
- flush overrides any stall combination; the killed entry never reaches MEM.
- rst asserted mid-multi-cycle op discards hilo_temp_o/cnt_o.
- No arithmetic is performed; widths are passed through unchanged.

Optional Feature:
- Macro: EX_MEM_PERF_EN.
- Defined:
  - Adds outputs perf_bubbles (32) and perf_holds (32).
  - perf_bubbles increments on each bubble cycle, whether from rule 2 or rule 3.
  - perf_holds increments on each hold cycle.
  - Both counters saturate at 0xFFFFFFFF and reset to 0 on rst.
- Undefined: the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package/defines:
  - NOP_OP, ZeroWord, NOPRegAddr, WriteDisable.
  - Stall-index constants per stage.
  - The pipe_action encoding: RESET, FLUSH, BUBBLE, HOLD, ADVANCE.
- One natural sub-module: pipe_stage_ctl. It is combinational, takes rst/flush/stall/STAGE_IDX, and emits the pipe_action. It is reused by the if_id, id_ex and mem_wb successors.

Test Plan:
- Advance: rst low, stall=0, ex_wd=5, ex_wreg=1, ex_wdata=0x1234, ex_valid=1 -> next cycle mem_wd=5, mem_wreg=1, mem_wdata=0x1234, mem_valid=1, cnt_o=0.
- Bubble with save: stall=6'b001000 (EX stalled, MEM not), ex_cnt=1, ex_hilo_temp=0xDEAD_BEEF_0000_0001 -> mem_wreg=0, mem_aluop=NOP, mem_valid=0, cnt_o=1, hilo_temp_o=0xDEADBEEF00000001.
- Hold: stall=6'b011000 for 3 cycles after an advance of wdata=0xAA -> mem_wdata stays 0xAA, mem_valid stays 1, and cnt_o/hilo_temp_o are unchanged throughout.
- Flush over stall: flush=1 with stall=6'b011000 -> bubble outputs, cnt_o=0, hilo_temp_o=0.
- Reset mid-op: cnt_o=1 held, then rst=1 for 1 cycle -> all outputs 0, mem_aluop=NOP_OP; with EX_MEM_PERF_EN defined, both counters are 0.
- Perf (EX_MEM_PERF_EN defined): 4 bubble cycles plus 2 hold cycles -> perf_bubbles=4, perf_holds=2; preload near saturation -> the counter stops at 0xFFFFFFFF.

Source files
------------

// File: rtl/ex_mem_pipe_pkg.sv
// Shared constants and pipeline-action encoding for the MIPS pipeline
// registers (if_id, id_ex, ex_mem, mem_wb).
package ex_mem_pipe_pkg;

  localparam logic [7:0]  NOP_OP       = 8'h00;
  localparam logic [31:0] ZeroWord     = 32'h0000_0000;
  localparam logic [4:0]  NOPRegAddr   = 5'b00000;
  localparam logic        WriteDisable = 1'b0;

  // Bit positions of each stage inside the ctrl stall vector.
  localparam int STALL_PC  = 0;
  localparam int STALL_IF  = 1;
  localparam int STALL_ID  = 2;
  localparam int STALL_EX  = 3;
  localparam int STALL_MEM = 4;
  localparam int STALL_WB  = 5;

  // What a pipeline register does on the coming clock edge.
  typedef enum logic [2:0] {
    ACT_RESET   = 3'd0,
    ACT_FLUSH   = 3'd1,
    ACT_BUBBLE  = 3'd2,
    ACT_HOLD    = 3'd3,
    ACT_ADVANCE = 3'd4
  } pipe_action_e;

  // Both flush and a downstream-free stall insert a bubble into the next stage.
  function automatic logic is_bubble(input pipe_action_e a);
    return (a == ACT_FLUSH) || (a == ACT_BUBBLE);
  endfunction

endpackage

// File: rtl/ex_mem_pipe_ctl.sv
// pipe_stage_ctl: decodes rst/flush/stall into one pipe_action for the
// pipeline register that owns stall bit STAGE_IDX (its successor owns
// STAGE_IDX+1). Purely combinational.
module pipe_stage_ctl
  import ex_mem_pipe_pkg::*;
#(
  parameter int STALL_W   = 6,
  parameter int STAGE_IDX = 3
) (
  input  logic               rst,
  input  logic               flush,
  input  logic [STALL_W-1:0] stall,
  output pipe_action_e       action,
  output logic               illegal_o
);

  logic s_e;
  logic s_m;
  logic unused_stall;

  assign s_e          = stall[STAGE_IDX];
  assign s_m          = stall[STAGE_IDX+1];
  assign unused_stall = ^stall;

  // Priority decode; a stalled successor with a running producer is illegal
  // and is treated as a hold so nothing is lost.
  always_comb begin
    action    = ACT_ADVANCE;
    illegal_o = !s_e && s_m;
    if (rst)              action = ACT_RESET;
    else if (flush)       action = ACT_FLUSH;
    else if (s_e && !s_m) action = ACT_BUBBLE;
    else if (s_m)         action = ACT_HOLD;
  end

endmodule

// File: rtl/ex_mem_pipe.sv
// ex_mem_pipe: EX->MEM pipeline register with stall hold, bubble insertion,
// flush and a valid bit, plus storage of multi-cycle EX progress
// (hilo_temp/cnt) across a stall.
// Optional build macro EX_MEM_PERF_EN adds saturating bubble/hold counters.
//
// Handshake: there is no valid/ready pair; ctrl's stall vector is the
// back-pressure. stall[STAGE_IDX] means EX cannot hand over, stall[STAGE_IDX+1]
// means MEM cannot accept; mem_valid qualifies every mem_* output.
module ex_mem_pipe
  import ex_mem_pipe_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int ALUOP_W    = 8,
  parameter int CNT_W      = 2,
  parameter int STALL_W    = 6,
  parameter int STAGE_IDX  = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [STALL_W-1:0]    stall,
  input  logic                  flush,
  input  logic                  ex_valid,
  input  logic [REG_ADDR_W-1:0] ex_wd,
  input  logic                  ex_wreg,
  input  logic [DATA_W-1:0]     ex_wdata,
  input  logic [DATA_W-1:0]     ex_hi,
  input  logic [DATA_W-1:0]     ex_lo,
  input  logic                  ex_whilo,
  input  logic [ALUOP_W-1:0]    ex_aluop,
  input  logic [DATA_W-1:0]     ex_mem_addr,
  input  logic [DATA_W-1:0]     ex_reg2,
  input  logic [2*DATA_W-1:0]   ex_hilo_temp,
  input  logic [CNT_W-1:0]      ex_cnt,
  output logic                  mem_valid,
  output logic [REG_ADDR_W-1:0] mem_wd,
  output logic                  mem_wreg,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [DATA_W-1:0]     mem_hi,
  output logic [DATA_W-1:0]     mem_lo,
  output logic                  mem_whilo,
  output logic [ALUOP_W-1:0]    mem_aluop,
  output logic [DATA_W-1:0]     mem_mem_addr,
  output logic [DATA_W-1:0]     mem_reg2,
  output logic [2*DATA_W-1:0]   hilo_temp_o,
  output logic [CNT_W-1:0]      cnt_o
`ifdef EX_MEM_PERF_EN
  ,
  output logic [31:0]           perf_bubbles,
  output logic [31:0]           perf_holds
`endif
);

  pipe_action_e action;
  logic         illegal_stall;

  logic                  valid_q, valid_d;
  logic [REG_ADDR_W-1:0] wd_q, wd_d;
  logic                  wreg_q, wreg_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [DATA_W-1:0]     hi_q, hi_d;
  logic [DATA_W-1:0]     lo_q, lo_d;
  logic                  whilo_q, whilo_d;
  logic [ALUOP_W-1:0]    aluop_q, aluop_d;
  logic [DATA_W-1:0]     addr_q, addr_d;
  logic [DATA_W-1:0]     reg2_q, reg2_d;
  logic [2*DATA_W-1:0]   hilo_temp_q, hilo_temp_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  pipe_stage_ctl #(
    .STALL_W   (STALL_W),
    .STAGE_IDX (STAGE_IDX)
  ) u_ctl (
    .rst       (rst),
    .flush     (flush),
    .stall     (stall),
    .action    (action),
    .illegal_o (illegal_stall)
  );

  // Next-state for the MEM entry and the saved multi-cycle progress.
  always_comb begin
    valid_d     = valid_q;
    wd_d        = wd_q;
    wreg_d      = wreg_q;
    wdata_d     = wdata_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    whilo_d     = whilo_q;
    aluop_d     = aluop_q;
    addr_d      = addr_q;
    reg2_d      = reg2_q;
    hilo_temp_d = hilo_temp_q;
    cnt_d       = cnt_q;
    if (action != ACT_HOLD) begin
      // Reset, flush and stall bubble all leave an empty MEM entry behind.
      valid_d     = 1'b0;
      wd_d        = REG_ADDR_W'(NOPRegAddr);
      wreg_d      = WriteDisable;
      wdata_d     = DATA_W'(ZeroWord);
      hi_d        = DATA_W'(ZeroWord);
      lo_d        = DATA_W'(ZeroWord);
      whilo_d     = WriteDisable;
      aluop_d     = ALUOP_W'(NOP_OP);
      addr_d      = DATA_W'(ZeroWord);
      reg2_d      = DATA_W'(ZeroWord);
      hilo_temp_d = '0;
      cnt_d       = '0;
    end
    if (action == ACT_BUBBLE) begin
      // EX is stuck mid-op: keep its partial result so it can resume.
      hilo_temp_d = ex_hilo_temp;
      cnt_d       = ex_cnt;
    end else if (action == ACT_ADVANCE) begin
      valid_d = ex_valid;
      wd_d    = ex_wd;
      wreg_d  = ex_wreg;
      wdata_d = ex_wdata;
      hi_d    = ex_hi;
      lo_d    = ex_lo;
      whilo_d = ex_whilo;
      aluop_d = ex_aluop;
      addr_d  = ex_mem_addr;
      reg2_d  = ex_reg2;
    end
  end

  // Pipeline register; reset is folded into the action decode.
  always_ff @(posedge clk) begin
    valid_q     <= valid_d;
    wd_q        <= wd_d;
    wreg_q      <= wreg_d;
    wdata_q     <= wdata_d;
    hi_q        <= hi_d;
    lo_q        <= lo_d;
    whilo_q     <= whilo_d;
    aluop_q     <= aluop_d;
    addr_q      <= addr_d;
    reg2_q      <= reg2_d;
    hilo_temp_q <= hilo_temp_d;
    cnt_q       <= cnt_d;
  end

  assign mem_valid    = valid_q;
  assign mem_wd       = wd_q;
  assign mem_wreg     = wreg_q;
  assign mem_wdata    = wdata_q;
  assign mem_hi       = hi_q;
  assign mem_lo       = lo_q;
  assign mem_whilo    = whilo_q;
  assign mem_aluop    = aluop_q;
  assign mem_mem_addr = addr_q;
  assign mem_reg2     = reg2_q;
  assign hilo_temp_o  = hilo_temp_q;
  assign cnt_o        = cnt_q;

  // ctrl must never stall MEM while letting EX run.
  a_legal_stall: assert property (@(posedge clk) disable iff (rst) !illegal_stall);

`ifdef EX_MEM_PERF_EN
  logic [31:0] perf_bubbles_q, perf_bubbles_d;
  logic [31:0] perf_holds_q, perf_holds_d;

  // Saturating event counters for bubble and hold cycles.
  always_comb begin
    perf_bubbles_d = perf_bubbles_q;
    perf_holds_d   = perf_holds_q;
    if (action == ACT_RESET) begin
      perf_bubbles_d = '0;
      perf_holds_d   = '0;
    end else if (is_bubble(action)) begin
      if (perf_bubbles_q != 32'hFFFF_FFFF) perf_bubbles_d = perf_bubbles_q + 32'd1;
    end else if (action == ACT_HOLD) begin
      if (perf_holds_q != 32'hFFFF_FFFF) perf_holds_d = perf_holds_q + 32'd1;
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    perf_bubbles_q <= perf_bubbles_d;
    perf_holds_q   <= perf_holds_d;
  end

  assign perf_bubbles = perf_bubbles_q;
  assign perf_holds   = perf_holds_q;
`endif

endmodule

// File: tb/tb_ex_mem_pipe.sv
// Testbench for ex_mem_pipe: table of directed vectors applied in order,
// plus hand sequences for back-to-back advance and (with EX_MEM_PERF_EN)
// the performance counters.
module tb_ex_mem_pipe;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic [5:0]   stall;
  logic         flush;
  logic         ex_valid;
  logic [4:0]   ex_wd;
  logic         ex_wreg;
  logic [31:0]  ex_wdata, ex_hi, ex_lo, ex_mem_addr, ex_reg2;
  logic         ex_whilo;
  logic [7:0]   ex_aluop;
  logic [63:0]  ex_hilo_temp;
  logic [1:0]   ex_cnt;
  logic         mem_valid, mem_wreg, mem_whilo;
  logic [4:0]   mem_wd;
  logic [31:0]  mem_wdata, mem_hi, mem_lo, mem_mem_addr, mem_reg2;
  logic [7:0]   mem_aluop;
  logic [63:0]  hilo_temp_o;
  logic [1:0]   cnt_o;
`ifdef EX_MEM_PERF_EN
  logic [31:0]  perf_bubbles, perf_holds;
`endif

  ex_mem_pipe dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .ex_valid(ex_valid), .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata),
    .ex_hi(ex_hi), .ex_lo(ex_lo), .ex_whilo(ex_whilo), .ex_aluop(ex_aluop),
    .ex_mem_addr(ex_mem_addr), .ex_reg2(ex_reg2), .ex_hilo_temp(ex_hilo_temp),
    .ex_cnt(ex_cnt),
    .mem_valid(mem_valid), .mem_wd(mem_wd), .mem_wreg(mem_wreg),
    .mem_wdata(mem_wdata), .mem_hi(mem_hi), .mem_lo(mem_lo),
    .mem_whilo(mem_whilo), .mem_aluop(mem_aluop), .mem_mem_addr(mem_mem_addr),
    .mem_reg2(mem_reg2), .hilo_temp_o(hilo_temp_o), .cnt_o(cnt_o)
`ifdef EX_MEM_PERF_EN
    , .perf_bubbles(perf_bubbles), .perf_holds(perf_holds)
`endif
  );

  // ---------------- vector table ----------------
  typedef struct {
    logic        valid;
    logic [4:0]  wd;
    logic [31:0] wdata;
    logic [7:0]  aluop;
    logic [1:0]  cnt;
    logic [63:0] ht;
  } payload_t;

  typedef struct {
    logic        rst;
    logic        flush;
    logic [5:0]  stall;
    payload_t    p;
    int          exp_src;   // row whose payload must sit in MEM, -1 = empty entry
    logic [1:0]  exp_cnt;
    logic [63:0] exp_ht;
  } vec_t;

  localparam int NV = 18;
  localparam logic [5:0] S_NONE = 6'b000000;
  localparam logic [5:0] S_EX   = 6'b001000;
  localparam logic [5:0] S_EXM  = 6'b011000;

  vec_t vecs[NV];
  int   tests = 0;
  int   fails = 0;

  function automatic vec_t mk(input logic r, input logic f, input logic [5:0] s,
                              input logic v, input logic [4:0] wd, input logic [31:0] wdata,
                              input logic [7:0] op, input logic [1:0] c, input logic [63:0] ht,
                              input int src, input logic [1:0] ec, input logic [63:0] eht);
    vec_t t;
    t.rst = r; t.flush = f; t.stall = s;
    t.p.valid = v; t.p.wd = wd; t.p.wdata = wdata; t.p.aluop = op; t.p.cnt = c; t.p.ht = ht;
    t.exp_src = src; t.exp_cnt = ec; t.exp_ht = eht;
    return t;
  endfunction

  // Side fields are spread out from wdata so every output carries distinct data.
  function automatic logic [31:0] hi_of(input logic [31:0] w);   return {w[15:0], w[31:16]}; endfunction
  function automatic logic [31:0] lo_of(input logic [31:0] w);   return ~w;                  endfunction
  function automatic logic [31:0] addr_of(input logic [31:0] w); return w + 32'h100;         endfunction
  function automatic logic [31:0] reg2_of(input logic [31:0] w); return w ^ 32'hFFFF_0000;   endfunction

  // ---------------- driver ----------------
  task automatic drive(input logic r, input logic f, input logic [5:0] s, input payload_t p);
    rst = r; flush = f; stall = s;
    ex_valid = p.valid; ex_wd = p.wd; ex_wreg = (p.wd != 5'd0); ex_wdata = p.wdata;
    ex_hi = hi_of(p.wdata); ex_lo = lo_of(p.wdata); ex_whilo = p.wdata[0];
    ex_aluop = p.aluop; ex_mem_addr = addr_of(p.wdata); ex_reg2 = reg2_of(p.wdata);
    ex_hilo_temp = p.ht; ex_cnt = p.cnt;
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input int row, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
    end
  endtask

  // Compares every output with the payload that ought to be in MEM.
  task automatic check_outputs(input int row, input logic empty, input payload_t p,
                               input logic [1:0] ec, input logic [63:0] eht);
    payload_t z;
    z.valid = 1'b0; z.wd = '0; z.wdata = '0; z.aluop = 8'h00; z.cnt = '0; z.ht = '0;
    if (empty) begin
      check("mem_valid", row, 64'(mem_valid), 64'(0));
      check("mem_wd", row, 64'(mem_wd), 64'(0));
      check("mem_wreg", row, 64'(mem_wreg), 64'(0));
      check("mem_wdata", row, 64'(mem_wdata), 64'(0));
      check("mem_hi", row, 64'(mem_hi), 64'(0));
      check("mem_lo", row, 64'(mem_lo), 64'(0));
      check("mem_whilo", row, 64'(mem_whilo), 64'(0));
      check("mem_aluop", row, 64'(mem_aluop), 64'(z.aluop));
      check("mem_mem_addr", row, 64'(mem_mem_addr), 64'(0));
      check("mem_reg2", row, 64'(mem_reg2), 64'(0));
    end else begin
      check("mem_valid", row, 64'(mem_valid), 64'(p.valid));
      check("mem_wd", row, 64'(mem_wd), 64'(p.wd));
      check("mem_wreg", row, 64'(mem_wreg), 64'(p.wd != 5'd0));
      check("mem_wdata", row, 64'(mem_wdata), 64'(p.wdata));
      check("mem_hi", row, 64'(mem_hi), 64'(hi_of(p.wdata)));
      check("mem_lo", row, 64'(mem_lo), 64'(lo_of(p.wdata)));
      check("mem_whilo", row, 64'(mem_whilo), 64'(p.wdata[0]));
      check("mem_aluop", row, 64'(mem_aluop), 64'(p.aluop));
      check("mem_mem_addr", row, 64'(mem_mem_addr), 64'(addr_of(p.wdata)));
      check("mem_reg2", row, 64'(mem_reg2), 64'(reg2_of(p.wdata)));
    end
    check("cnt_o", row, 64'(cnt_o), 64'(ec));
    check("hilo_temp_o", row, hilo_temp_o, eht);
  endtask

  // ---------------- test ----------------
  initial begin
    payload_t q;
    // rst flush stall  valid wd  wdata          aluop  cnt ht                       src ecnt eht
    vecs[0]  = mk(1, 0, S_NONE, 1, 5'd5,  32'h0000_1234, 8'h21, 2, 64'h55,              -1, 0, 64'h0);
    vecs[1]  = mk(0, 0, S_NONE, 1, 5'd5,  32'h0000_1234, 8'h21, 1, 64'h11,               1, 0, 64'h0);
    vecs[2]  = mk(0, 0, S_EX,   1, 5'd7,  32'h0000_0055, 8'h22, 1, 64'hDEAD_BEEF_0000_0001, -1, 1, 64'hDEAD_BEEF_0000_0001);
    vecs[3]  = mk(0, 0, S_NONE, 1, 5'd9,  32'h0000_00AA, 8'h24, 2, 64'h77,               3, 0, 64'h0);
    vecs[4]  = mk(0, 0, S_EXM,  1, 5'd3,  32'h0000_00BB, 8'h25, 3, 64'h99,               3, 0, 64'h0);
    vecs[5]  = mk(0, 0, S_EXM,  0, 5'd4,  32'h0000_00CC, 8'h26, 1, 64'h98,               3, 0, 64'h0);
    vecs[6]  = mk(0, 0, S_EXM,  1, 5'd0,  32'h0000_00DD, 8'h27, 2, 64'h97,               3, 0, 64'h0);
    vecs[7]  = mk(0, 0, S_EX,   1, 5'd8,  32'h0000_0101, 8'h28, 2, 64'hCAFE,            -1, 2, 64'hCAFE);
    vecs[8]  = mk(0, 0, S_EXM,  1, 5'd8,  32'h0000_0202, 8'h29, 3, 64'h1,               -1, 2, 64'hCAFE);
    vecs[9]  = mk(0, 1, S_EXM,  1, 5'd4,  32'h0000_0303, 8'h2A, 1, 64'h2,               -1, 0, 64'h0);
    vecs[10] = mk(0, 0, S_NONE, 0, 5'd6,  32'h0000_0600, 8'h30, 3, 64'h3,               10, 0, 64'h0);
    vecs[11] = mk(0, 0, S_EX,   1, 5'd2,  32'h0000_0707, 8'h31, 1, 64'h1234_5678_9ABC_DEF0, -1, 1, 64'h1234_5678_9ABC_DEF0);
    vecs[12] = mk(1, 0, S_EXM,  1, 5'd2,  32'h0000_0808, 8'h32, 2, 64'h4,               -1, 0, 64'h0);
    vecs[13] = mk(0, 0, S_NONE, 1, 5'd31, 32'hFFFF_FFFF, 8'hFF, 3, 64'h5,               13, 0, 64'h0);
    vecs[14] = mk(0, 1, S_NONE, 1, 5'd1,  32'h0000_0909, 8'h33, 1, 64'h6,               -1, 0, 64'h0);
    vecs[15] = mk(0, 1, S_EX,   1, 5'd1,  32'h0000_0A0A, 8'h34, 3, 64'h7,               -1, 0, 64'h0);
    vecs[16] = mk(0, 0, 6'b000111, 1, 5'd2, 32'h0F0F_0F0F, 8'h2C, 2, 64'h8,             16, 0, 64'h0);
    vecs[17] = mk(0, 0, 6'b111000, 1, 5'd3, 32'h0000_0B0B, 8'h35, 1, 64'h9,             16, 0, 64'h0);

    drive(1'b1, 1'b0, S_NONE, vecs[0].p);
    @(posedge clk);
    #1;

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].rst, vecs[i].flush, vecs[i].stall, vecs[i].p);
      @(posedge clk);
      #1;
      if (vecs[i].exp_src < 0) check_outputs(i, 1'b1, vecs[i].p, vecs[i].exp_cnt, vecs[i].exp_ht);
      else check_outputs(i, 1'b0, vecs[vecs[i].exp_src].p, vecs[i].exp_cnt, vecs[i].exp_ht);
    end

    // Back-to-back advances: each instruction shows up exactly one edge later.
    for (int k = 0; k < 5; k++) begin
      q.valid = k[0]; q.wd = 5'(k + 10); q.wdata = 32'h1000 + 32'(k * 17);
      q.aluop = 8'(8'h40 + k); q.cnt = 2'(k); q.ht = 64'(k + 100);
      drive(1'b0, 1'b0, S_NONE, q);
      @(posedge clk);
      #1;
      check_outputs(100 + k, 1'b0, q, 2'd0, 64'h0);
    end

`ifdef EX_MEM_PERF_EN
    // Counters: one reset cycle, four bubbles, two holds.
    drive(1'b1, 1'b0, S_NONE, q); @(posedge clk); #1;
    check("perf_bubbles_rst", 200, 64'(perf_bubbles), 64'd0);
    check("perf_holds_rst", 200, 64'(perf_holds), 64'd0);
    drive(1'b0, 1'b1, S_NONE, q); @(posedge clk); #1;
    drive(1'b0, 1'b1, S_EXM,  q); @(posedge clk); #1;
    drive(1'b0, 1'b0, S_EX,   q); @(posedge clk); #1;
    drive(1'b0, 1'b0, S_EX,   q); @(posedge clk); #1;
    drive(1'b0, 1'b0, S_EXM,  q); @(posedge clk); #1;
    drive(1'b0, 1'b0, S_EXM,  q); @(posedge clk); #1;
    drive(1'b0, 1'b0, S_NONE, q); @(posedge clk); #1;
    check("perf_bubbles", 201, 64'(perf_bubbles), 64'd4);
    check("perf_holds", 201, 64'(perf_holds), 64'd2);
    // Saturation: preload one below the top, then three more bubbles.
    dut.perf_bubbles_q = 32'hFFFF_FFFE;
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b0, S_EX, q); @(posedge clk); #1;
    end
    check("perf_bubbles_sat", 202, 64'(perf_bubbles), 64'hFFFF_FFFF);
    drive(1'b1, 1'b0, S_NONE, q); @(posedge clk); #1;
    check("perf_bubbles_rst2", 203, 64'(perf_bubbles), 64'd0);
    check("perf_holds_rst2", 203, 64'(perf_holds), 64'd0);
`endif

    // ---------------- report ----------------
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
